pll_lock_sequencer: RTL

Controls the DDR3 PLL from the fabric side: it issues the PLL reset, qualifies the lock output, enables the two PLL output clocks in order, and releases the DDR3 subsystem reset. It runs on the free-running 50 MHz board clock that also feeds the PLL input. It re-runs the whole sequence on loss of lock, on lock timeout, or on software request.

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_lock_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the DDR3 PLL lock sequencer: state encoding and counter sizing.
package pll_seq_pkg;

  // Debug-visible encoding; software and the bench decode these values directly.
  typedef enum logic [2:0] {
    StRstPll   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StEnClk0   = 3'd3,
    StEnClk2   = 3'd4,
    StRun      = 3'd5
  } seq_state_e;

  localparam int unsigned RetryWidth = 4;

  // Width of the shared phase counter: enough bits to reach (largest duration - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d,
                                            input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the local clock domain.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Fabric-side DDR3 PLL bring-up: pulses the PLL reset, qualifies lock, enables clkout0 then
// clkout2, and finally releases the DDR3 subsystem reset. Any loss of lock or a software
// request sends it back to the start.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned ENCLK_GAP     = 16,
  parameter int unsigned RELEASE_DELAY = 256,
  parameter int unsigned MAX_RETRY     = 15
) (
  input  logic                  clkin,
  input  logic                  rstn,
  input  logic                  lock,
  input  logic                  relock_req,
  output logic                  pll_reset,
  output logic                  enclk0,
  output logic                  enclk2,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic [RetryWidth-1:0] retry_cnt,
  output logic [2:0]            state
);

  localparam int unsigned CntW =
      cnt_width(RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT, ENCLK_GAP, RELEASE_DELAY);

  // Terminal counts: a phase of N cycles ends when the counter shows N-1.
  localparam logic [CntW-1:0] RstLast     = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(ENCLK_GAP - 1);
  localparam logic [CntW-1:0] ReleaseLast = CntW'(RELEASE_DELAY - 1);
  localparam logic [RetryWidth-1:0] RetryMax = RetryWidth'(MAX_RETRY);

  seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RetryWidth-1:0] retry_q, retry_d;
  logic pll_reset_q, pll_reset_d;
  logic enclk0_q, enclk0_d;
  logic enclk2_q, enclk2_d;
  logic run_q, run_d;
  logic lock_s;
  logic restart;
  logic bump_retry;

  sync_2ff #(
    .Width (1)
  ) u_lock_sync (
    .clk  (clkin),
    .rstn (rstn),
    .d    (lock),
    .q    (lock_s)
  );

  // Next-state decode; a software request always takes precedence over lock-based decisions.
  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    bump_retry = 1'b0;
    case (state_q)
      StRstPll: begin
        if (relock_req) begin
          restart = 1'b1;
        end else if (cnt_q == RstLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        if (relock_req) begin
          state_d = StRstPll;
        end else if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = StRstPll;
          bump_retry = 1'b1;
        end
      end
      StStable: begin
        if (relock_req) begin
          state_d = StRstPll;
        end else if (!lock_s) begin
          // A glitch before qualification is not a retry; the timeout window starts afresh.
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StEnClk0;
        end
      end
      StEnClk0, StEnClk2, StRun: begin
        if (relock_req) begin
          state_d = StRstPll;
        end else if (!lock_s) begin
          state_d    = StRstPll;
          bump_retry = 1'b1;
        end else if (state_q == StEnClk0 && cnt_q == GapLast) begin
          state_d = StEnClk2;
        end else if (state_q == StEnClk2 && cnt_q == ReleaseLast) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRstPll;
      end
    endcase
  end

  // Shared phase counter: cleared on every entry (including an RST_PLL restart), parked in RUN.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || restart) begin
      cnt_d = '0;
    end else if (state_q != StRun) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Retry counter saturates so a persistently bad PLL never appears healthy through wrap.
  always_comb begin
    retry_d = retry_q;
    if (bump_retry && retry_q != RetryMax) begin
      retry_d = retry_q + RetryWidth'(1);
    end
  end

  // Outputs are decoded from the next state so they change together with the state register.
  always_comb begin
    pll_reset_d = (state_d == StRstPll);
    enclk0_d    = (state_d == StEnClk0) || (state_d == StEnClk2) || (state_d == StRun);
    enclk2_d    = (state_d == StEnClk2) || (state_d == StRun);
    run_d       = (state_d == StRun);
  end

  // State, counter and registered outputs; reset parks the PLL in reset with clocks gated.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StRstPll;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      enclk0_q    <= 1'b0;
      enclk2_q    <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      enclk0_q    <= enclk0_d;
      enclk2_q    <= enclk2_d;
      run_q       <= run_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign enclk0    = enclk0_q;
  assign enclk2    = enclk2_q;
  assign sys_rst_n = run_q;
  assign ready     = run_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
